// File: rtl/wshb_mire_writer.sv
// Wishbone master that writes a grid test pattern into the framebuffer, one word per pixel
// in raster order, dropping cyc for one cycle after every BURST acknowledged writes.
module wshb_mire_writer #(
    parameter int          HDISP    = 800,
    parameter int          VDISP    = 480,
    parameter int          BURST    = 64,
    parameter logic [31:0] BASE_ADR = 32'd0,
    parameter int          GRID     = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        cyc,
    output logic        stb,
    output logic        we,
    output logic [31:0] adr,
    output logic [3:0]  sel,
    output logic [31:0] dat_ms,
    input  logic        ack
);

    localparam int XW = $clog2(HDISP);
    localparam int YW = $clog2(VDISP);
    localparam int CW = $clog2(BURST + 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WRITE   = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    localparam logic [31:0] GRID_MASK = 32'(GRID - 1);

    logic [1:0]    state_reg, state_next;
    logic          cyc_reg, cyc_next;
    logic [XW-1:0] x_reg, x_next;
    logic [YW-1:0] y_reg, y_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [31:0]   adr_reg, adr_next;
    logic [31:0]   dat_reg, dat_next;

    // GRID is a power of two, so the modulo reduces to masking the low counter bits.
    function automatic logic [31:0] pixel(input logic [XW-1:0] px, input logic [YW-1:0] py);
        logic on_line;
        on_line = ((32'(px) & GRID_MASK) == 32'd0) || ((32'(py) & GRID_MASK) == 32'd0);
        return on_line ? 32'h00FF_FFFF : 32'h0000_0000;
    endfunction

    always_comb begin
        state_next = state_reg;
        cyc_next   = cyc_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        cnt_next   = cnt_reg;
        adr_next   = adr_reg;
        case (state_reg)
            IDLE: begin
                state_next = WRITE;
                cyc_next   = 1'b1;
            end
            WRITE: begin
                if (ack && cyc_reg) begin
                    adr_next = adr_reg + 32'd4;
                    if (x_reg == XW'(HDISP - 1)) begin
                        x_next = '0;
                        if (y_reg == YW'(VDISP - 1)) begin
                            y_next   = '0;
                            adr_next = BASE_ADR;
                        end else begin
                            y_next = y_reg + 1'b1;
                        end
                    end else begin
                        x_next = x_reg + 1'b1;
                    end
                    // Burst boundary and frame wrap are independent and may coincide.
                    if (cnt_reg == CW'(BURST - 1)) begin
                        cnt_next   = '0;
                        state_next = RELEASE;
                        cyc_next   = 1'b0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            RELEASE: begin
                state_next = WRITE;
                cyc_next   = 1'b1;
            end
            default: begin
                state_next = IDLE;
                cyc_next   = 1'b0;
            end
        endcase
        dat_next = pixel(x_next, y_next);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cyc_reg   <= 1'b0;
            x_reg     <= '0;
            y_reg     <= '0;
            cnt_reg   <= '0;
            adr_reg   <= BASE_ADR;
            dat_reg   <= pixel('0, '0);
        end else begin
            state_reg <= state_next;
            cyc_reg   <= cyc_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            cnt_reg   <= cnt_next;
            adr_reg   <= adr_next;
            dat_reg   <= dat_next;
        end
    end

    assign cyc    = cyc_reg;
    assign stb    = cyc_reg;
    assign we     = 1'b1;
    assign sel    = 4'hF;
    assign adr    = adr_reg;
    assign dat_ms = dat_reg;

endmodule

// File: tb/tb_wshb_mire_writer.sv
// Bench for wshb_mire_writer: two instances (BURST=4 and BURST=5) on a 32x4 frame,
// checked cycle by cycle against a write-index model of the expected pixel stream.
module tb_wshb_mire_writer;

    localparam int H = 32;
    localparam int V = 4;

    logic clk = 1'b0;
    logic rst4, rst5, ack;
    logic        cyc4, stb4, we4, cyc5, stb5, we5;
    logic [31:0] adr4, dat4, adr5, dat5;
    logic [3:0]  sel4, sel5;

    int errors = 0;
    int checks = 0;
    int dsel   = 0;   // 0: BURST=4 instance, 1: BURST=5 instance
    int k      = 0;   // acknowledged writes since the selected instance left reset
    bit exp_rel = 1'b0;

    always #5 clk = ~clk;

    wshb_mire_writer #(.HDISP(H), .VDISP(V), .BURST(4), .BASE_ADR(32'h0), .GRID(16)) dut4 (
        .clk(clk), .rst(rst4), .cyc(cyc4), .stb(stb4), .we(we4), .adr(adr4),
        .sel(sel4), .dat_ms(dat4), .ack(ack)
    );

    wshb_mire_writer #(.HDISP(H), .VDISP(V), .BURST(5), .BASE_ADR(32'h100), .GRID(16)) dut5 (
        .clk(clk), .rst(rst5), .cyc(cyc5), .stb(stb5), .we(we5), .adr(adr5),
        .sel(sel5), .dat_ms(dat5), .ack(ack)
    );

    function automatic logic [31:0] o_cyc(); return dsel != 0 ? 32'(cyc5) : 32'(cyc4); endfunction
    function automatic logic [31:0] o_stb(); return dsel != 0 ? 32'(stb5) : 32'(stb4); endfunction
    function automatic logic [31:0] o_we();  return dsel != 0 ? 32'(we5)  : 32'(we4);  endfunction
    function automatic logic [31:0] o_sel(); return dsel != 0 ? 32'(sel5) : 32'(sel4); endfunction
    function automatic logic [31:0] o_adr(); return dsel != 0 ? adr5 : adr4; endfunction
    function automatic logic [31:0] o_dat(); return dsel != 0 ? dat5 : dat4; endfunction

    function automatic int burst_len(); return dsel != 0 ? 5 : 4; endfunction
    function automatic logic [31:0] base(); return dsel != 0 ? 32'h100 : 32'h0; endfunction

    // Expected write n: pixel index n mod frame size, raster order.
    function automatic logic [31:0] exp_adr(input int n);
        return base() + 32'(4 * (n % (H * V)));
    endfunction

    function automatic logic [31:0] exp_pix(input int n);
        int p, x, y;
        p = n % (H * V);
        x = p % H;
        y = p / H;
        return (x % 16 == 0 || y % 16 == 0) ? 32'h00FF_FFFF : 32'h0000_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s (dut%0d write %0d): observed %h expected %h", tag, dsel + 4, k, obs, exp);
        end
    endtask

    task automatic chk_reset();
        chk("rst_cyc", o_cyc(), 32'd0);
        chk("rst_stb", o_stb(), 32'd0);
        chk("rst_we",  o_we(),  32'd1);
        chk("rst_sel", o_sel(), 32'hF);
        chk("rst_adr", o_adr(), base());
        chk("rst_dat", o_dat(), 32'h00FF_FFFF);
    endtask

    // Each iteration is one clock; outputs are sampled and ack is driven at the falling edge.
    task automatic run_writes(input int n, input int maxd);
        int done = 0;
        int wait_c;
        wait_c = $urandom_range(maxd, 0);
        while (done < n) begin
            @(negedge clk);
            if (exp_rel) begin
                chk("release_cyc", o_cyc(), 32'd0);
                chk("release_stb", o_stb(), 32'd0);
                chk("release_adr", o_adr(), exp_adr(k));
                ack = 1'($urandom_range(1, 0));   // spurious ack must be ignored
                exp_rel = 1'b0;
            end else begin
                chk("write_cyc", o_cyc(), 32'd1);
                chk("write_stb", o_stb(), 32'd1);
                chk("write_we",  o_we(),  32'd1);
                chk("write_sel", o_sel(), 32'hF);
                chk("write_adr", o_adr(), exp_adr(k));
                chk("write_dat", o_dat(), exp_pix(k));
                if (wait_c == 0) begin
                    ack = 1'b1;
                    k++;
                    done++;
                    if (k % burst_len() == 0) exp_rel = 1'b1;
                    wait_c = $urandom_range(maxd, 0);
                end else begin
                    ack = 1'b0;
                    wait_c--;
                end
            end
        end
    endtask

    initial begin
        rst4 = 1'b1;
        rst5 = 1'b1;
        ack  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        dsel = 1; chk_reset();
        dsel = 0; chk_reset();

        // Leave reset with a spurious ack presented during IDLE.
        rst4 = 1'b0;
        ack  = 1'b1;
        k = 0; exp_rel = 1'b0;
        run_writes(136, 0);     // ack tied high across the frame wrap
        run_writes(140, 3);     // random ack latency, covers a second wrap

        // Finish any pending release, then reset mid-write with ack withheld.
        if (exp_rel) begin
            @(negedge clk);
            chk("pre_rst_release", o_cyc(), 32'd0);
            exp_rel = 1'b0;
        end
        @(negedge clk);
        chk("pre_rst_cyc", o_cyc(), 32'd1);
        ack  = 1'b0;
        rst4 = 1'b1;
        @(negedge clk);
        chk_reset();
        rst4 = 1'b0;
        ack  = 1'b1;
        k = 0; exp_rel = 1'b0;
        run_writes(20, 3);

        // BURST=5 instance: releases not aligned with the frame wrap.
        @(negedge clk);
        rst4 = 1'b1;
        dsel = 1;
        chk_reset();
        rst5 = 1'b0;
        ack  = 1'b1;
        k = 0; exp_rel = 1'b0;
        run_writes(260, 2);

        @(negedge clk);
        ack = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
